// File: rtl/arith_cmd_driver.sv
// Initiator for the registered arithmetic unit: command in, operand/enable out, result back out.
// Optional response statistics counters are built when ARITH_DRV_STATS_EN is defined.
module arith_cmd_driver #(
   parameter int unsigned IN_WIDTH  = 16,
   parameter int unsigned OUT_WIDTH = 16,
   parameter int unsigned TIMEOUT   = 8
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [IN_WIDTH-1:0]  cmd_a,
   input  logic [IN_WIDTH-1:0]  cmd_b,
   input  logic [1:0]           cmd_op,
   output logic [IN_WIDTH-1:0]  alu_a,
   output logic [IN_WIDTH-1:0]  alu_b,
   output logic [1:0]           alu_op,
   output logic                 alu_enable,
   input  logic [OUT_WIDTH-1:0] alu_out,
   input  logic                 alu_carry,
   input  logic                 alu_flag,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [OUT_WIDTH-1:0] rsp_data,
   output logic                 rsp_carry,
   output logic                 rsp_err,
   output logic [15:0]          op_count,
   output logic [15:0]          err_count
);

   localparam int unsigned CNT_W   = 8;
   localparam int unsigned STAT_W  = 16;
   localparam logic [1:0]  OP_DIV  = 2'b11;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t               r_state, w_state_nxt;
   logic                 r_cmd_ready, w_cmd_ready_nxt;
   logic [IN_WIDTH-1:0]  r_alu_a, w_alu_a_nxt;
   logic [IN_WIDTH-1:0]  r_alu_b, w_alu_b_nxt;
   logic [1:0]           r_alu_op, w_alu_op_nxt;
   logic                 r_alu_enable, w_alu_enable_nxt;
   logic                 r_rsp_valid, w_rsp_valid_nxt;
   logic [OUT_WIDTH-1:0] r_rsp_data, w_rsp_data_nxt;
   logic                 r_rsp_carry, w_rsp_carry_nxt;
   logic                 r_rsp_err, w_rsp_err_nxt;
   logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
   logic                 r_dbz, w_dbz_nxt;

   // State and registered outputs
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state      <= S_IDLE;
         r_cmd_ready  <= 1'b1;
         r_alu_a      <= '0;
         r_alu_b      <= '0;
         r_alu_op     <= '0;
         r_alu_enable <= 1'b0;
         r_rsp_valid  <= 1'b0;
         r_rsp_data   <= '0;
         r_rsp_carry  <= 1'b0;
         r_rsp_err    <= 1'b0;
         r_cnt        <= '0;
         r_dbz        <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cmd_ready  <= w_cmd_ready_nxt;
         r_alu_a      <= w_alu_a_nxt;
         r_alu_b      <= w_alu_b_nxt;
         r_alu_op     <= w_alu_op_nxt;
         r_alu_enable <= w_alu_enable_nxt;
         r_rsp_valid  <= w_rsp_valid_nxt;
         r_rsp_data   <= w_rsp_data_nxt;
         r_rsp_carry  <= w_rsp_carry_nxt;
         r_rsp_err    <= w_rsp_err_nxt;
         r_cnt        <= w_cnt_nxt;
         r_dbz        <= w_dbz_nxt;
      end
   end

   // Next state and next output values
   always_comb begin
      w_state_nxt      = r_state;
      w_alu_a_nxt      = r_alu_a;
      w_alu_b_nxt      = r_alu_b;
      w_alu_op_nxt     = r_alu_op;
      w_alu_enable_nxt = 1'b0;
      w_rsp_data_nxt   = r_rsp_data;
      w_rsp_carry_nxt  = r_rsp_carry;
      w_rsp_err_nxt    = r_rsp_err;
      w_cnt_nxt        = r_cnt;
      w_dbz_nxt        = r_dbz;

      unique case (r_state)
         S_IDLE: begin
            if (cmd_valid) begin
               w_alu_a_nxt  = cmd_a;
               w_alu_b_nxt  = cmd_b;
               w_alu_op_nxt = cmd_op;
               // Screened divides spend their ISSUE cycle with the unit left idle
               w_dbz_nxt        = (cmd_op == OP_DIV) && (cmd_b == '0);
               w_alu_enable_nxt = !w_dbz_nxt;
               w_state_nxt      = S_ISSUE;
            end
         end
         S_ISSUE: begin
            w_cnt_nxt = '0;
            if (r_dbz) begin
               w_rsp_data_nxt  = '1;
               w_rsp_carry_nxt = 1'b0;
               w_rsp_err_nxt   = 1'b1;
               w_dbz_nxt       = 1'b0;
               w_state_nxt     = S_RESP;
            end else begin
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (alu_flag) begin
               w_rsp_data_nxt  = alu_out;
               w_rsp_carry_nxt = alu_carry;
               w_rsp_err_nxt   = 1'b0;
               w_state_nxt     = S_RESP;
            end else if (r_cnt == CNT_LAST) begin
               w_rsp_data_nxt  = '0;
               w_rsp_carry_nxt = 1'b0;
               w_rsp_err_nxt   = 1'b1;
               w_state_nxt     = S_RESP;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase

      w_cmd_ready_nxt = (w_state_nxt == S_IDLE);
      w_rsp_valid_nxt = (w_state_nxt == S_RESP);
   end

   assign cmd_ready  = r_cmd_ready;
   assign alu_a      = r_alu_a;
   assign alu_b      = r_alu_b;
   assign alu_op     = r_alu_op;
   assign alu_enable = r_alu_enable;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_data   = r_rsp_data;
   assign rsp_carry  = r_rsp_carry;
   assign rsp_err    = r_rsp_err;

`ifdef ARITH_DRV_STATS_EN
   logic              w_rsp_hs;
   logic [STAT_W-1:0] r_op_count;
   logic [STAT_W-1:0] r_err_count;

   assign w_rsp_hs = r_rsp_valid && rsp_ready;

   // Saturating response statistics
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_op_count  <= '0;
         r_err_count <= '0;
      end else if (w_rsp_hs) begin
         if (r_op_count != '1) begin
            r_op_count <= r_op_count + STAT_W'(1);
         end
         if (r_rsp_err && (r_err_count != '1)) begin
            r_err_count <= r_err_count + STAT_W'(1);
         end
      end
   end

   assign op_count  = r_op_count;
   assign err_count = r_err_count;
`else
   assign op_count  = STAT_W'(0);
   assign err_count = STAT_W'(0);
`endif

endmodule

// File: tb/tb_arith_cmd_driver.sv
// Directed bench for arith_cmd_driver with a registered arithmetic-unit model.
module tb_arith_cmd_driver;

   logic        CLK;
   logic        RST;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [15:0] cmd_a, cmd_b;
   logic [1:0]  cmd_op;
   logic [15:0] alu_a, alu_b;
   logic [1:0]  alu_op;
   logic        alu_enable;
   logic [15:0] alu_out;
   logic        alu_carry;
   logic        alu_flag;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_data;
   logic        rsp_carry;
   logic        rsp_err;
   logic [15:0] op_count, err_count;

   int checks;
   int failures;
   int stats_on;

   logic        model_en;
   logic        late_flag;
   logic        m_flag;
   logic [15:0] m_out;
   logic        m_carry;

   arith_cmd_driver #(.IN_WIDTH(16), .OUT_WIDTH(16), .TIMEOUT(8)) dut (
      .CLK(CLK), .RST(RST),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_enable(alu_enable),
      .alu_out(alu_out), .alu_carry(alu_carry), .alu_flag(alu_flag),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_err(rsp_err),
      .op_count(op_count), .err_count(err_count)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Registered arithmetic unit: result and one-cycle flag the cycle after enable
   function automatic logic [16:0] alu_calc(input logic [15:0] a, input logic [15:0] b,
                                            input logic [1:0] op);
      logic [31:0] p;
      case (op)
         2'b00:   alu_calc = {1'b0, a} + {1'b0, b};
         2'b01:   alu_calc = {1'b0, a} - {1'b0, b};
         2'b10:   begin p = a * b; alu_calc = {|p[31:16], p[15:0]}; end
         default: alu_calc = (b == 16'h0) ? 17'h0 : {1'b0, a / b};
      endcase
   endfunction

   always @(posedge CLK) begin
      logic [16:0] r;
      r = alu_calc(alu_a, alu_b, alu_op);
      m_flag <= alu_enable & model_en;
      if (alu_enable) begin
         m_out   <= r[15:0];
         m_carry <= r[16];
      end
   end

   assign alu_out   = m_out;
   assign alu_carry = m_carry;
   assign alu_flag  = m_flag | late_flag;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [1:0]  op;
      logic [15:0] d;
      logic        c;
      logic        e;
      int          lat;
      int          en;
   } vec_t;

   vec_t vecs[8];
   vec_t v_to;
   vec_t v_bp;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_ready();
      int g = 0;
      while (!cmd_ready && g < 40) begin
         tick();
         g++;
      end
      chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
   endtask

   // Issue one command and wait for its response, checking latency, enables and payload
   task automatic issue_wait(input vec_t v);
      int lat = 0;
      int en = 0;
      int consec = 0;
      logic prev = 1'b0;
      wait_ready();
      cmd_a = v.a; cmd_b = v.b; cmd_op = v.op; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      while (!rsp_valid && lat < 40) begin
         if (alu_enable) begin
            en++;
            if (prev) consec = 1;
         end
         prev = alu_enable;
         chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
         tick();
         lat++;
      end
      chk("rsp_valid_seen", 32'(rsp_valid), 32'd1);
      chk("latency", 32'(lat), 32'(v.lat));
      chk("enable_pulses", 32'(en), 32'(v.en));
      chk("enable_consecutive", 32'(consec), 32'd0);
      chk("rsp_data", 32'(rsp_data), 32'(v.d));
      chk("rsp_carry", 32'(rsp_carry), 32'(v.c));
      chk("rsp_err", 32'(rsp_err), 32'(v.e));
      chk("cmd_ready_in_resp", 32'(cmd_ready), 32'd0);
   endtask

   task automatic handshake();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("rsp_valid_cleared", 32'(rsp_valid), 32'd0);
      chk("cmd_ready_after_hs", 32'(cmd_ready), 32'd1);
   endtask

   initial begin
      int lat;
      checks = 0; failures = 0;
`ifdef ARITH_DRV_STATS_EN
      stats_on = 1;
`else
      stats_on = 0;
`endif
      vecs[0] = '{16'h0003, 16'h0004, 2'b00, 16'h0007, 1'b0, 1'b0, 2, 1};
      vecs[1] = '{16'hFFFF, 16'h0002, 2'b00, 16'h0001, 1'b1, 1'b0, 2, 1};
      vecs[2] = '{16'h0005, 16'h0003, 2'b01, 16'h0002, 1'b0, 1'b0, 2, 1};
      vecs[3] = '{16'h0003, 16'h0005, 2'b01, 16'hFFFE, 1'b1, 1'b0, 2, 1};
      vecs[4] = '{16'h0100, 16'h0100, 2'b10, 16'h0000, 1'b1, 1'b0, 2, 1};
      vecs[5] = '{16'h0007, 16'h0006, 2'b10, 16'h002A, 1'b0, 1'b0, 2, 1};
      vecs[6] = '{16'h0064, 16'h0007, 2'b11, 16'h000E, 1'b0, 1'b0, 2, 1};
      vecs[7] = '{16'h0010, 16'h0000, 2'b11, 16'hFFFF, 1'b0, 1'b1, 1, 0};
      v_to    = '{16'h0009, 16'h0001, 2'b00, 16'h0000, 1'b0, 1'b1, 9, 1};
      v_bp    = vecs[2];

      RST = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0;
      rsp_ready = 1'b0; model_en = 1'b1; late_flag = 1'b0;
      #12;
      chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_alu_enable", 32'(alu_enable), 32'd0);
      chk("reset_rsp_word", {15'd0, rsp_carry, rsp_err, rsp_data}, 32'd0);
      chk("reset_alu_word", {alu_op, alu_a, alu_b[13:0]}, 32'd0);
      #10 RST = 1'b1;

      // Table of single commands, including the divide-by-zero screen
      for (int i = 0; i < 8; i++) begin
         issue_wait(vecs[i]);
         handshake();
      end
      chk("op_count_table", 32'(op_count), stats_on ? 32'd8 : 32'd0);
      chk("err_count_table", 32'(err_count), stats_on ? 32'd1 : 32'd0);

      // Timeout with no flag, then a late flag that must be ignored
      model_en = 1'b0;
      issue_wait(v_to);
      late_flag = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("late_flag_hold", {14'd0, rsp_valid, rsp_err, rsp_data}, {14'd0, 1'b1, 1'b1, 16'h0000});
      end
      handshake();
      tick();
      chk("late_flag_idle", {30'd0, cmd_ready, rsp_valid}, {30'd0, 1'b1, 1'b0});
      late_flag = 1'b0;
      model_en = 1'b1;
      issue_wait(vecs[0]);
      handshake();

      // Back-pressure, then a command presented during the handshake cycle
      issue_wait(v_bp);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("bp_hold", {14'd0, rsp_valid, cmd_ready, rsp_data}, {14'd0, 1'b1, 1'b0, 16'h0002});
      end
      rsp_ready = 1'b1;
      cmd_valid = 1'b1; cmd_a = 16'h0003; cmd_b = 16'h0004; cmd_op = 2'b00;
      tick();
      rsp_ready = 1'b0;
      chk("bp_hs_no_accept", {29'd0, rsp_valid, cmd_ready, alu_enable}, {29'd0, 1'b0, 1'b1, 1'b0});
      tick();
      cmd_valid = 1'b0;
      chk("bp_next_accept", {30'd0, cmd_ready, alu_enable}, {30'd0, 1'b0, 1'b1});
      lat = 0;
      while (!rsp_valid && lat < 40) begin tick(); lat++; end
      chk("bp_next_data", 32'(rsp_data), 32'h0007);
      handshake();

      // Reset while waiting on the unit
      model_en = 1'b0;
      wait_ready();
      cmd_a = 16'h1234; cmd_b = 16'h0001; cmd_op = 2'b00; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      tick();
      tick();
      RST = 1'b0;
      #1;
      chk("midreset_ctrl", {29'd0, cmd_ready, rsp_valid, alu_enable}, {29'd0, 1'b1, 1'b0, 1'b0});
      chk("midreset_alu_a", 32'(alu_a), 32'd0);
      chk("midreset_counts", {op_count, err_count}, 32'd0);
      #2 RST = 1'b1;
      model_en = 1'b1;
      lat = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (rsp_valid) lat++;
      end
      chk("midreset_no_rsp", 32'(lat), 32'd0);

      // Back-to-back mixed commands with the consumer always ready
      rsp_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         vec_t v;
         v = vecs[(k == 3) ? 6 : (k == 2) ? 5 : (k == 1) ? 2 : 0];
         wait_ready();
         cmd_a = v.a; cmd_b = v.b; cmd_op = v.op; cmd_valid = 1'b1;
         tick();
         cmd_valid = 1'b0;
         lat = 0;
         while (!rsp_valid && lat < 40) begin tick(); lat++; end
         chk("b2b_data", {15'd0, rsp_valid, rsp_data}, {15'd0, 1'b1, v.d});
         tick();
      end
      rsp_ready = 1'b0;
      chk("b2b_op_count", 32'(op_count), stats_on ? 32'd4 : 32'd0);
      chk("b2b_err_count", 32'(err_count), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
